// File: rtl/core_l1i_cache_pkg.sv
// ============================================================================
// core_l1i_cache_pkg : shared geometry defaults and FSM encodings for the L1I
// Revision: 1.0
// ============================================================================
`default_nettype none

package core_l1i_cache_pkg;

  localparam int L1I_DEF_LINE_WORDS = 4;
  localparam int L1I_DEF_SETS       = 16;

  localparam logic [0:0] c_l1i_idle   = 1'b0;
  localparam logic [0:0] c_l1i_refill = 1'b1;

endpackage

`default_nettype wire

// File: rtl/core_l1i_array.sv
// ============================================================================
// core_l1i_array : flop-based valid/tag/data storage, async read, sync write
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_l1i_array import core_l1i_cache_pkg::*; #(
  parameter int LINE_WORDS = L1I_DEF_LINE_WORDS,
  parameter int SETS       = L1I_DEF_SETS,
  parameter int TAG_W      = 24
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [$clog2(SETS)-1:0]       rd_index,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_data,
  input  logic                          wr_en,
  input  logic [$clog2(SETS)-1:0]       wr_index,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [31:0]                   wr_data,
  input  logic                          fill_en,
  input  logic                          fill_valid,
  input  logic [TAG_W-1:0]              fill_tag,
  input  logic                          flush
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS][LINE_WORDS];

  // Flush wins over a same-cycle fill so a line completing under fence.i stays invalid
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else if (fill_en) begin
      r_valid[wr_index] <= fill_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_data[wr_index][wr_word] <= wr_data;
    end
    if (fill_en) begin
      r_tag[wr_index] <= fill_tag;
    end
  end

  assign rd_valid = r_valid[rd_index];
  assign rd_tag   = r_tag[rd_index];
  assign rd_data  = r_data[rd_index][rd_word];

endmodule

`default_nettype wire

// File: rtl/core_l1i_cache.sv
// ============================================================================
// core_l1i_cache : direct-mapped L1 instruction cache with word-serial refill
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_l1i_cache import core_l1i_cache_pkg::*; #(
  parameter int LINE_WORDS = L1I_DEF_LINE_WORDS,
  parameter int SETS       = L1I_DEF_SETS
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] l1i_addr_in,
  input  logic        l1i_val_in,
  input  logic        l1i_flush_in,
  output logic [31:0] l1i_data_out,
  output logic        l1i_ack_out,
  output logic        l1i_stall_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ack_in,
  input  logic [31:0] mem_data_in
);

  localparam int c_wb    = $clog2(LINE_WORDS);
  localparam int c_ib    = $clog2(SETS);
  localparam int c_tag_w = 32 - c_wb - c_ib - 2;
  localparam int c_tag_lo = c_wb + c_ib + 2;
  localparam logic [c_wb-1:0] c_last_beat = c_wb'(LINE_WORDS - 1);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [31:0]        r_base;
  logic [c_wb-1:0]    r_beat;
  logic               r_flush_pend;

  logic [c_wb-1:0]    w_word;
  logic [c_ib-1:0]    w_index;
  logic [c_tag_w-1:0] w_tag;
  logic               w_rd_valid;
  logic [c_tag_w-1:0] w_rd_tag;
  logic [31:0]        w_rd_data;
  logic               w_hit;
  logic               w_miss;
  logic               w_beat_ack;
  logic               w_last_ack;
  logic               w_unused;

  assign w_word   = l1i_addr_in[c_wb+1:2];
  assign w_index  = l1i_addr_in[c_tag_lo-1:c_wb+2];
  assign w_tag    = l1i_addr_in[31:c_tag_lo];
  assign w_unused = ^l1i_addr_in[1:0];

  assign w_hit      = l1i_val_in & w_rd_valid & (w_rd_tag == w_tag) & (r_state == c_l1i_idle);
  assign w_miss     = (r_state == c_l1i_idle) & l1i_val_in & ~w_hit;
  assign w_beat_ack = (r_state == c_l1i_refill) & mem_ack_in;
  // Explicit compare; the beat counter's natural wrap is never used as the end marker
  assign w_last_ack = w_beat_ack & (r_beat == c_last_beat);

  core_l1i_array #(
    .LINE_WORDS (LINE_WORDS),
    .SETS       (SETS),
    .TAG_W      (c_tag_w)
  ) u_array (
    .clk        (clk),
    .n_rst      (n_rst),
    .rd_index   (w_index),
    .rd_word    (w_word),
    .rd_valid   (w_rd_valid),
    .rd_tag     (w_rd_tag),
    .rd_data    (w_rd_data),
    .wr_en      (w_beat_ack),
    .wr_index   (r_base[c_tag_lo-1:c_wb+2]),
    .wr_word    (r_beat),
    .wr_data    (mem_data_in),
    .fill_en    (w_last_ack),
    .fill_valid (~(r_flush_pend | l1i_flush_in)),
    .fill_tag   (r_base[31:c_tag_lo]),
    .flush      (l1i_flush_in)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= c_l1i_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_l1i_idle:   if (w_miss)     w_state_nxt = c_l1i_refill;
      c_l1i_refill: if (w_last_ack) w_state_nxt = c_l1i_idle;
      default:                      w_state_nxt = c_l1i_idle;
    endcase
  end

  // Refill bookkeeping: the latched base keeps the burst going through redirects
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_base       <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_miss) begin
        r_base <= {l1i_addr_in[31:c_wb+2], {(c_wb+2){1'b0}}};
        r_beat <= '0;
      end else if (w_beat_ack) begin
        r_beat <= r_beat + c_wb'(1);
      end
      if (w_last_ack) begin
        r_flush_pend <= 1'b0;
      end else if (l1i_flush_in && (r_state == c_l1i_refill)) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    l1i_ack_out   = w_hit;
    l1i_data_out  = w_hit ? w_rd_data : 32'd0;
    l1i_stall_out = w_miss | (r_state == c_l1i_refill);
    mem_req_out   = (r_state == c_l1i_refill);
    mem_addr_out  = 32'd0;
    if (r_state == c_l1i_refill) begin
      mem_addr_out = r_base + {{(30-c_wb){1'b0}}, r_beat, 2'b00};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_l1i_cache.sv
// ============================================================================
// tb_core_l1i_cache : scoreboard bench for the L1 instruction cache
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_core_l1i_cache;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] l1i_addr_in = '0;
  logic        l1i_val_in = 1'b0;
  logic        l1i_flush_in = 1'b0;
  logic [31:0] l1i_data_out;
  logic        l1i_ack_out;
  logic        l1i_stall_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_ack_in = 1'b0;
  logic [31:0] mem_data_in = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  core_l1i_cache #(.LINE_WORDS(4), .SETS(16)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .l1i_addr_in   (l1i_addr_in),
    .l1i_val_in    (l1i_val_in),
    .l1i_flush_in  (l1i_flush_in),
    .l1i_data_out  (l1i_data_out),
    .l1i_ack_out   (l1i_ack_out),
    .l1i_stall_out (l1i_stall_out),
    .mem_req_out   (mem_req_out),
    .mem_addr_out  (mem_addr_out),
    .mem_ack_in    (mem_ack_in),
    .mem_data_in   (mem_data_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic idle_inputs();
    l1i_val_in   = 1'b0;
    l1i_flush_in = 1'b0;
    mem_ack_in   = 1'b0;
    mem_data_in  = '0;
  endtask

  // One fetch until hit: refill addresses and the hit word come from the scoreboard
  task automatic fetch(input logic [31:0] addr, input int period, input int fills,
                       input int exp_stall, input int flush_mode, input bit spurious);
    int stalls = 0;
    int wait_cnt = 0;
    int acks = 0;
    int cyc = 0;
    bit done = 1'b0;
    bit flushed = 1'b0;
    logic [31:0] base;
    logic [31:0] exp;
    base = {addr[31:4], 4'h0};
    q_data.push_back(mem_model({addr[31:2], 2'b00}));
    for (int f = 0; f < fills; f++)
      for (int b = 0; b < 4; b++)
        q_addr.push_back(base + 32'(4 * b));
    while (!done && cyc < 200) begin
      @(negedge clk);
      l1i_val_in   = 1'b1;
      l1i_addr_in  = addr;
      l1i_flush_in = 1'b0;
      if ((flush_mode == 1 && cyc == 0) ||
          (flush_mode == 2 && !flushed && mem_req_out && acks == 1)) begin
        l1i_flush_in = 1'b1;
        flushed = 1'b1;
      end
      checks++;
      if (mem_req_out) begin
        if (q_addr.size() == 0 || mem_addr_out !== q_addr[0]) begin
          errors++;
          $display("FAIL refill_addr @%h got %h expected %h", addr, mem_addr_out,
                   (q_addr.size() != 0) ? q_addr[0] : 32'hFFFF_FFFF);
        end
        if (wait_cnt == period - 1) begin
          mem_ack_in  = 1'b1;
          mem_data_in = mem_model(mem_addr_out);
          wait_cnt = 0;
          acks++;
          if (q_addr.size() != 0) void'(q_addr.pop_front());
        end else begin
          mem_ack_in  = 1'b0;
          mem_data_in = $urandom;
          wait_cnt++;
        end
      end else begin
        if (mem_addr_out !== 32'd0) begin
          errors++;
          $display("FAIL idle_mem_addr @%h got %h expected 00000000", addr, mem_addr_out);
        end
        mem_ack_in  = spurious;
        mem_data_in = 32'hDEAD_BEEF;
      end
      #1;
      if (l1i_stall_out) stalls++;
      checks++;
      if (l1i_ack_out) begin
        done = 1'b1;
        if (q_data.size() == 0) begin
          errors++;
          $display("FAIL hit_data @%h unexpected ack data %h", addr, l1i_data_out);
        end else begin
          exp = q_data.pop_front();
          if (l1i_data_out !== exp) begin
            errors++;
            $display("FAIL hit_data @%h got %h expected %h", addr, l1i_data_out, exp);
          end
        end
      end else if (l1i_data_out !== 32'd0) begin
        errors++;
        $display("FAIL nohit_data @%h got %h expected 00000000", addr, l1i_data_out);
      end
      cyc++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fetch_timeout @%h got no ack expected ack within 200 cycles", addr);
    end
    checks++;
    if (stalls != exp_stall) begin
      errors++;
      $display("FAIL stall_cycles @%h got %0d expected %0d", addr, stalls, exp_stall);
    end
    checks++;
    if (q_addr.size() != 0) begin
      errors++;
      $display("FAIL refill_count @%h got %0d beats short expected 0", addr, q_addr.size());
    end
    q_addr.delete();
    q_data.delete();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({l1i_ack_out, l1i_stall_out, mem_req_out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got ack/stall/req %b expected 000",
               {l1i_ack_out, l1i_stall_out, mem_req_out});
    end
    checks++;
    if (mem_addr_out !== 32'd0 || l1i_data_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_buses got addr %h data %h expected 0", mem_addr_out, l1i_data_out);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_0204, 1, 1, 5, 0, 1'b0);
  endtask

  task automatic test_seq_hits();
    for (int i = 0; i < 4; i++) fetch(32'h0000_0200 + 32'(4 * i), 1, 0, 0, 0, 1'b0);
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0300, 1, 1, 5, 0, 1'b0);
    fetch(32'h0000_0200, 1, 1, 5, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    fetch(32'h1234_5670, 3, 1, 13, 0, 1'b1);
    fetch(32'h1234_567C, 1, 0, 0, 0, 1'b1);
  endtask

  task automatic test_flush_idle();
    fetch(32'h1234_5674, 1, 0, 0, 1, 1'b0);
    fetch(32'h1234_5674, 1, 1, 5, 0, 1'b0);
  endtask

  task automatic test_flush_refill();
    fetch(32'h0000_0400, 1, 2, 10, 2, 1'b0);
    fetch(32'h0000_0408, 1, 0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_refill();
    int acks = 0;
    int cyc = 0;
    bit fired = 1'b0;
    for (int b = 0; b < 4; b++) q_addr.push_back(32'h0000_0500 + 32'(4 * b));
    while (!fired && cyc < 50) begin
      @(negedge clk);
      if (mem_req_out && acks == 2) begin
        n_rst = 1'b0;
        idle_inputs();
        #1;
        fired = 1'b1;
        checks++;
        if ({l1i_stall_out, mem_req_out} !== 2'b00 || mem_addr_out !== 32'd0) begin
          errors++;
          $display("FAIL reset_abort got stall/req %b addr %h expected 00 00000000",
                   {l1i_stall_out, mem_req_out}, mem_addr_out);
        end
      end else begin
        l1i_val_in  = 1'b1;
        l1i_addr_in = 32'h0000_0500;
        mem_ack_in  = mem_req_out;
        mem_data_in = mem_model(mem_addr_out);
        if (mem_req_out) begin
          checks++;
          if (mem_addr_out !== q_addr[0]) begin
            errors++;
            $display("FAIL reset_refill_addr got %h expected %h", mem_addr_out, q_addr[0]);
          end
          void'(q_addr.pop_front());
          acks++;
        end
      end
      cyc++;
    end
    checks++;
    if (!fired) begin
      errors++;
      $display("FAIL reset_refill_timeout got %0d acks expected beat 2 reached", acks);
    end
    q_addr.delete();
    @(negedge clk);
    n_rst = 1'b1;
    fetch(32'h0000_0500, 1, 1, 5, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_conflict();
    test_wait_states();
    test_flush_idle();
    test_flush_refill();
    test_reset_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
